// File: rtl/psu_seq_pkg.sv
// ---------------------------------------------------------------------------
// psu_seq_pkg
// Shared definitions for the PSU power sequencer: FSM state encodings,
// timer width, default clock multiplier and the elaboration-time helper
// that turns a microsecond parameter into a timer compare value.
// ---------------------------------------------------------------------------
package psu_seq_pkg;

    localparam int STATE_W          = 3;
    localparam int TIMER_W          = 24;
    localparam int CLK_MULT_DEFAULT = 2;   // 2 MHz reference clock

    typedef enum logic [STATE_W-1:0] {
        ST_OFF     = 3'd0,
        ST_WAIT_OK = 3'd1,
        ST_STABLE  = 3'd2,
        ST_ON      = 3'd3,
        ST_OFF_DLY = 3'd4,
        ST_FAULT   = 3'd5
    } state_e;

    // Compare value for a timed state: the timer expires on the last cycle of
    // the interval, i.e. when count == t_us*mult - 1. A zero duration is
    // treated as 1 us, and anything beyond the timer range is clamped to the
    // largest representable interval.
    function automatic logic [TIMER_W-1:0] calc_limit(input int t_us, input int mult);
        longint cycles;
        cycles = longint'((t_us <= 0) ? 1 : t_us) * longint'((mult <= 0) ? 1 : mult);
        if (cycles > (longint'(1) << TIMER_W)) begin
            cycles = longint'(1) << TIMER_W;
        end
        return TIMER_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/psu_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// psu_seq_ctrl_if
// Groups the PSU sequencer's request/status signals.
//   iPwrReq   : level request for PSU on (synchronous to iClk)
//   iPsuPwrOk : PSU PWROK (asynchronous)
//   iFault    : external fault, active-high (asynchronous)
//   oPsOn_n   : PSU enable, active-low
//   oPwrGood  : power good (state ON only)
//   oFault    : fault latched (state FAULT only)
//   oState    : current FSM state encoding
// master drives the requests and observes status; slave is the sequencer.
// ---------------------------------------------------------------------------
interface psu_seq_ctrl_if;
    import psu_seq_pkg::*;

    logic               iPwrReq;
    logic               iPsuPwrOk;
    logic               iFault;
    logic               oPsOn_n;
    logic               oPwrGood;
    logic               oFault;
    logic [STATE_W-1:0] oState;

    modport master (
        output iPwrReq, iPsuPwrOk, iFault,
        input  oPsOn_n, oPwrGood, oFault, oState
    );

    modport slave (
        input  iPwrReq, iPsuPwrOk, iFault,
        output oPsOn_n, oPwrGood, oFault, oState
    );

endinterface

// File: rtl/seq_timer.sv
// ---------------------------------------------------------------------------
// seq_timer
// Shared saturating interval timer for the PSU sequencer.
//   iClk, iRst_n : clock, synchronous active-low reset
//   clear        : zero the count on the next clock (takes priority)
//   enable       : count one per cycle
//   limit        : compare value (interval length in cycles minus one)
//   expire       : high while enabled and count has reached limit
// ---------------------------------------------------------------------------
module seq_timer
    import psu_seq_pkg::*;
(
    input  logic               iClk,
    input  logic               iRst_n,
    input  logic               clear,
    input  logic               enable,
    input  logic [TIMER_W-1:0] limit,
    output logic               expire
);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    // Saturate at all-ones so a long dwell can never wrap into a false expiry.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = enable && (count_q >= limit);

endmodule

// File: rtl/psu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// psu_seq_ctrl
// PSU power-on sequencer: asserts PS_ON on request, waits for PWROK (with
// timeout), requires PWROK to stay high for a stability interval before
// declaring power good, enforces a minimum off time, and latches faults.
//   iClk   : 2 MHz clock
//   iRst_n : synchronous active-low reset
//   bus    : psu_seq_ctrl_if.slave (requests in, PS_ON/status out)
// Parameters give durations in us; CLK_MULT is clock cycles per us.
// ---------------------------------------------------------------------------
module psu_seq_ctrl
    import psu_seq_pkg::*;
#(
    parameter int T_PWROK_TO_US = 20000,
    parameter int T_STABLE_US   = 1000,
    parameter int T_MIN_OFF_US  = 2000,
    parameter int CLK_MULT      = CLK_MULT_DEFAULT
) (
    input  logic           iClk,
    input  logic           iRst_n,
    psu_seq_ctrl_if.slave  bus
);

    localparam logic [TIMER_W-1:0] LIM_PWROK_TO = calc_limit(T_PWROK_TO_US, CLK_MULT);
    localparam logic [TIMER_W-1:0] LIM_STABLE   = calc_limit(T_STABLE_US,   CLK_MULT);
    localparam logic [TIMER_W-1:0] LIM_MIN_OFF  = calc_limit(T_MIN_OFF_US,  CLK_MULT);

    // Two-flop synchronizers for the asynchronous inputs.
    logic pwrok_meta_q, pwrok_meta_d, pwrok_sync_q, pwrok_sync_d;
    logic fault_meta_q, fault_meta_d, fault_sync_q, fault_sync_d;

    state_e state_q, state_d;
    logic   ps_on_n_q, ps_on_n_d;
    logic   pwr_good_q, pwr_good_d;
    logic   fault_q, fault_d;

    logic               tmr_clear;
    logic               tmr_en;
    logic [TIMER_W-1:0] tmr_limit;
    logic               tmr_expire;

    always_comb begin
        pwrok_meta_d = bus.iPsuPwrOk;
        pwrok_sync_d = pwrok_meta_q;
        fault_meta_d = bus.iFault;
        fault_sync_d = fault_meta_q;
    end

    // Timer is enabled only in the timed states; the compare value follows
    // the current state. Clearing on any state change means the count is
    // already zero on the first cycle of the new state.
    always_comb begin
        tmr_en    = 1'b0;
        tmr_limit = '1;
        unique case (state_q)
            ST_WAIT_OK: begin tmr_en = 1'b1; tmr_limit = LIM_PWROK_TO; end
            ST_STABLE:  begin tmr_en = 1'b1; tmr_limit = LIM_STABLE;   end
            ST_OFF_DLY: begin tmr_en = 1'b1; tmr_limit = LIM_MIN_OFF;  end
            default:    begin tmr_en = 1'b0; tmr_limit = '1;           end
        endcase
    end

    assign tmr_clear = (state_d != state_q);

    seq_timer u_timer (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .clear  (tmr_clear),
        .enable (tmr_en),
        .limit  (tmr_limit),
        .expire (tmr_expire)
    );

    // Next state. Within a state the PWROK/timeout exits are tested before
    // request withdrawal; an external fault overrides everything except when
    // already latched in FAULT, where only dropping the request exits.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OFF: begin
                if (bus.iPwrReq) state_d = ST_WAIT_OK;
            end
            ST_WAIT_OK: begin
                if (pwrok_sync_q)      state_d = ST_STABLE;
                else if (tmr_expire)   state_d = ST_FAULT;
                else if (!bus.iPwrReq) state_d = ST_OFF_DLY;
            end
            ST_STABLE: begin
                // A PWROK drop here is a fault, never a silent timer restart.
                if (!pwrok_sync_q)     state_d = ST_FAULT;
                else if (!bus.iPwrReq) state_d = ST_OFF_DLY;
                else if (tmr_expire)   state_d = ST_ON;
            end
            ST_ON: begin
                if (!pwrok_sync_q)     state_d = ST_FAULT;
                else if (!bus.iPwrReq) state_d = ST_OFF_DLY;
            end
            ST_OFF_DLY: begin
                if (tmr_expire) state_d = ST_OFF;
            end
            ST_FAULT: begin
                if (!bus.iPwrReq) state_d = ST_OFF_DLY;
            end
            default: state_d = ST_FAULT;
        endcase

        if (fault_sync_q && (state_q != ST_FAULT)) begin
            state_d = ST_FAULT;
        end
    end

    // Outputs are decoded from the next state and registered, so they move on
    // the same edge as the state register.
    always_comb begin
        ps_on_n_d  = !((state_d == ST_WAIT_OK) || (state_d == ST_STABLE) || (state_d == ST_ON));
        pwr_good_d = (state_d == ST_ON);
        fault_d    = (state_d == ST_FAULT);
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            pwrok_meta_q <= 1'b0;
            pwrok_sync_q <= 1'b0;
            fault_meta_q <= 1'b0;
            fault_sync_q <= 1'b0;
            state_q      <= ST_OFF;
            ps_on_n_q    <= 1'b1;
            pwr_good_q   <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            pwrok_meta_q <= pwrok_meta_d;
            pwrok_sync_q <= pwrok_sync_d;
            fault_meta_q <= fault_meta_d;
            fault_sync_q <= fault_sync_d;
            state_q      <= state_d;
            ps_on_n_q    <= ps_on_n_d;
            pwr_good_q   <= pwr_good_d;
            fault_q      <= fault_d;
        end
    end

    assign bus.oPsOn_n  = ps_on_n_q;
    assign bus.oPwrGood = pwr_good_q;
    assign bus.oFault   = fault_q;
    assign bus.oState   = state_q;

endmodule
